req_splitter: RTL and testbench
===============================

# req_splitter

Parametrised request splitter on the user-side request path. It accepts one `req_t` request on `s_req` and emits a stream of chunk requests on `m_req`, each at most `PARSE_SIZE` bytes long. Compared with the previous parser generation it has configurable chunk size, zero-bubble back-to-back operation (one chunk per cycle), correct zero-length handling and optional address-aligned splitting. It sits between the user request interface and the TLB/DMA request queues.

## Interface
Parameters:
- `PARSE_SIZE`, default `PMTU_BYTES`: maximum chunk length in bytes. Must be a power of two, ≥ 64 and ≤ 2^(LEN_BITS-1).
- `PARSE_BITS`, default `$clog2(PARSE_SIZE)`: derived. Not to be overridden.

Ports:
- `aclk`, in, 1: clock.
- `aresetn`, in, 1: reset, synchronous, active-low.
- `s_req`, `metaIntf.s`, `req_t`: incoming request (valid/ready/data).
- `m_req`, `metaIntf.m`, `req_t`: outgoing chunk requests.
- `busy`, out, 1: a request is being split; high from acceptance until its final chunk handshakes.
- `chunk_cnt`, out, 16: number of chunks emitted for the current or most recent request. Saturates at 0xFFFF.

## Operation
- States are `ST_IDLE` (no active request) and `ST_SPLIT` (output register holds a valid chunk).
- Acceptance: on an `s_req` handshake, latch all fields. Remaining length `rlen` = `len` and running address `raddr` = `vaddr`. Compute the first chunk into the output register, reset `chunk_cnt` to 1, and move to `ST_SPLIT`.
- Chunk length `clen`:
  - Unaligned: `min(rlen, PARSE_SIZE)`.
  - Aligned mode: `min(rlen, PARSE_SIZE - raddr[PARSE_BITS-1:0])`.
- Chunk fields:
  - `vaddr` = `raddr`, `len` = `clen`.
  - All other fields (opcode, mode, rdma, remote, pid, vfid, dest, strm, host, actv, offs) are copied unchanged.
  - `last` = original `last` on the final chunk, 0 on all others.
- Final chunk: `rlen - clen == 0`.
- On an `m_req` handshake of a non-final chunk:
  - `raddr += clen`, `rlen -= clen`.
  - Compute the next chunk and increment `chunk_cnt`.
- On an `m_req` handshake of the final chunk: return to `ST_IDLE`, unless a new request is accepted in the same cycle. In that case load the new request and stay in `ST_SPLIT`.
- `s_req.ready` = `(state==ST_IDLE) | (final_chunk & m_req.ready)`.
- Zero-length request: emit exactly one chunk with `len`=0, `vaddr`=`vaddr`, `last`=original `last`.
- Arithmetic:
  - `raddr` is `VADDR_BITS` wide and wraps modulo 2^VADDR_BITS with no error.
  - `rlen` is `LEN_BITS` wide and can never underflow.

## Timing
- Reset values: `m_req.valid`=0, `busy`=0, `chunk_cnt`=0, state `ST_IDLE`. `s_req.ready`=0 while `aresetn`=0, and 1 from the first cycle after reset.
- Latency: request accepted at cycle T → first chunk valid at T+1.
- Throughput: one chunk per cycle while `m_req.ready`=1. No idle cycle between consecutive requests.
- `m_req.data` is stable while `m_req.valid`=1 and `m_req.ready`=0 (AXI-style hold). `m_req.valid` never drops without a handshake.
- All outputs except `s_req.ready` are registered.
- A request of N chunks occupies the output for exactly N cycles at full downstream ready.
- Reset mid-request discards the request. No partial chunk is emitted after reset.

## Configuration
- `REQ_SPLIT_ALIGN_EN` defined: aligned mode.
  - The first chunk ends at the next `PARSE_SIZE` boundary of `vaddr`. All following chunks are boundary-aligned.
  - No chunk crosses a `PARSE_SIZE` boundary.
- Not defined: unaligned mode. Chunks are `PARSE_SIZE` long starting at `vaddr`, with only the last chunk shorter.

## Structure
- `req_t`, `LEN_BITS`, `VADDR_BITS`, `PMTU_BYTES` come from `lynxTypes`. Add a localparam `REQ_CHUNK_CNT_BITS = 16` to `lynxTypes`.
- One combinational sub-module, `req_chunk_calc`, takes `raddr`, `rlen` and the alignment flag and produces `clen` and `final`. It is used for both the accept and advance paths.

## Test plan
With `PARSE_SIZE`=4096:
- `len`=10000, `vaddr`=0x1000, `last`=1, unaligned → chunks (0x1000,4096,0), (0x2000,4096,0), (0x3000,1808,1); `chunk_cnt`=3.
- `REQ_SPLIT_ALIGN_EN`, `len`=5000, `vaddr`=0x1F00 → chunks (0x1F00,256,0), (0x2000,4096,0), (0x3000,648,last); no chunk crosses a 4 KiB boundary.
- `len`=0, `last`=1 → single chunk with `len`=0, `last`=1; `busy` high for 1 cycle.
- Two back-to-back 4096-byte requests with `m_req.ready`=1 → chunks on consecutive cycles; second request accepted in the final-chunk cycle.
- Random `m_req.ready` backpressure on a 3-chunk request → data held stable while stalled; exact chunk sequence preserved.
- `aresetn` asserted after the first chunk of a 3-chunk request → `m_req.valid`=0 and `busy`=0 next cycle; next request splits correctly.

Source files
------------

// File: rtl/lynxTypes.sv
// Shared user-side request types and widths.
// Contents: address/length widths, PMTU, chunk counter width, the req_t request
// record and the splitter state encoding.
package lynxTypes;

    localparam int unsigned VADDR_BITS         = 48;
    localparam int unsigned LEN_BITS           = 28;
    localparam int unsigned PMTU_BYTES         = 4096;
    localparam int unsigned REQ_CHUNK_CNT_BITS = 16;

    localparam int unsigned OPCODE_BITS = 5;
    localparam int unsigned PID_BITS    = 6;
    localparam int unsigned VFID_BITS   = 1;
    localparam int unsigned DEST_BITS   = 4;
    localparam int unsigned STRM_BITS   = 2;
    localparam int unsigned OFFS_BITS   = 6;

    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic                   mode;
        logic                   rdma;
        logic                   remote;
        logic [PID_BITS-1:0]    pid;
        logic [VFID_BITS-1:0]   vfid;
        logic [DEST_BITS-1:0]   dest;
        logic [STRM_BITS-1:0]   strm;
        logic                   host;
        logic                   actv;
        logic [OFFS_BITS-1:0]   offs;
        logic [VADDR_BITS-1:0]  vaddr;
        logic [LEN_BITS-1:0]    len;
        logic                   last;
    } req_t;

    typedef enum logic {
        ST_IDLE,
        ST_SPLIT
    } splitter_state_t;

endpackage

// File: rtl/metaIntf.sv
// Valid/ready metadata channel carrying one req_t per handshake.
// Signals: valid, ready, data (req_t).
// Modports: s (sink: receives valid/data, drives ready),
//           m (source: drives valid/data, receives ready).
interface metaIntf;
    import lynxTypes::*;

    logic valid;
    logic ready;
    req_t data;

    modport s (input valid, input data, output ready);
    modport m (output valid, output data, input ready);

endinterface

// File: rtl/req_chunk_calc.sv
// Combinational chunk-length calculator shared by the accept and advance paths.
// Ports:
//   raddr_lo  - low PARSE_BITS of the running address (only the offset matters)
//   rlen      - remaining length of the request
//   align     - 1: chunk stops at the next PARSE_SIZE boundary
//   clen      - length of the chunk starting at raddr
//   is_final  - this chunk consumes all remaining bytes
module req_chunk_calc
    import lynxTypes::*;
#(
    parameter int unsigned PARSE_SIZE = PMTU_BYTES,
    parameter int unsigned PARSE_BITS = $clog2(PARSE_SIZE)
) (
    input  logic [PARSE_BITS-1:0] raddr_lo,
    input  logic [LEN_BITS-1:0]   rlen,
    input  logic                  align,
    output logic [LEN_BITS-1:0]   clen,
    output logic                  is_final
);

    logic [LEN_BITS-1:0] limit;

    always_comb begin
        // Bytes available before the boundary; offset 0 gives a full PARSE_SIZE.
        limit    = align ? (LEN_BITS'(PARSE_SIZE) - LEN_BITS'(raddr_lo))
                         : LEN_BITS'(PARSE_SIZE);
        clen     = (rlen < limit) ? rlen : limit;
        is_final = (rlen <= limit);
    end

endmodule

// File: rtl/req_splitter.sv
// Splits one user request into a stream of chunk requests of at most PARSE_SIZE bytes,
// one chunk per cycle, with no bubble between consecutive requests.
// Build option: define REQ_SPLIT_ALIGN_EN to make chunks end on PARSE_SIZE boundaries
// of the virtual address (no chunk crosses a boundary); otherwise chunks are PARSE_SIZE
// long from vaddr and only the last one is shorter.
// Ports:
//   aclk, aresetn - clock, synchronous active-low reset
//   s_req         - incoming request (metaIntf sink)
//   m_req         - outgoing chunk requests (metaIntf source, registered)
//   busy          - a request is being split (acceptance until final chunk handshake)
//   chunk_cnt     - chunks emitted for the current/most recent request, saturating
module req_splitter
    import lynxTypes::*;
#(
    parameter int unsigned PARSE_SIZE = PMTU_BYTES,
    parameter int unsigned PARSE_BITS = $clog2(PARSE_SIZE)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    metaIntf.s                            s_req,
    metaIntf.m                            m_req,
    output logic                          busy,
    output logic [REQ_CHUNK_CNT_BITS-1:0] chunk_cnt
);

`ifdef REQ_SPLIT_ALIGN_EN
    localparam logic ALIGN = 1'b1;
`else
    localparam logic ALIGN = 1'b0;
`endif

    splitter_state_t state_q, state_d;
    logic [VADDR_BITS-1:0]         raddr_q, raddr_d;
    logic [LEN_BITS-1:0]           rlen_q, rlen_d;
    req_t                          out_q, out_d;
    logic                          last_q, last_d;
    logic                          final_q, final_d;
    logic [REQ_CHUNK_CNT_BITS-1:0] cnt_q, cnt_d;

    logic                  accept;
    logic                  m_hs;
    logic [VADDR_BITS-1:0] adv_addr;
    logic [LEN_BITS-1:0]   adv_len;
    logic [VADDR_BITS-1:0] calc_addr;
    logic [LEN_BITS-1:0]   calc_len;
    logic [LEN_BITS-1:0]   clen;
    logic                  is_final;

    // Combinational ready lets a new request load in the final-chunk cycle.
    assign s_req.ready = aresetn & ((state_q == ST_IDLE) | (final_q & m_req.ready));
    assign accept      = s_req.valid & s_req.ready;
    assign m_hs        = (state_q == ST_SPLIT) & m_req.ready;

    // raddr_q/rlen_q describe the chunk currently in out_q; advance past it.
    assign adv_addr  = raddr_q + VADDR_BITS'(out_q.len);
    assign adv_len   = rlen_q - out_q.len;
    assign calc_addr = accept ? s_req.data.vaddr : adv_addr;
    assign calc_len  = accept ? s_req.data.len : adv_len;

    req_chunk_calc #(
        .PARSE_SIZE (PARSE_SIZE),
        .PARSE_BITS (PARSE_BITS)
    ) u_chunk_calc (
        .raddr_lo (calc_addr[PARSE_BITS-1:0]),
        .rlen     (calc_len),
        .align    (ALIGN),
        .clen     (clen),
        .is_final (is_final)
    );

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        rlen_d  = rlen_q;
        out_d   = out_q;
        last_d  = last_q;
        final_d = final_q;
        cnt_d   = cnt_q;

        if (accept) begin
            state_d     = ST_SPLIT;
            raddr_d     = s_req.data.vaddr;
            rlen_d      = s_req.data.len;
            out_d       = s_req.data;
            out_d.len   = clen;
            out_d.last  = s_req.data.last & is_final;
            last_d      = s_req.data.last;
            final_d     = is_final;
            cnt_d       = REQ_CHUNK_CNT_BITS'(1);
        end else if (m_hs) begin
            if (final_q) begin
                state_d = ST_IDLE;
            end else begin
                raddr_d     = adv_addr;
                rlen_d      = adv_len;
                out_d.vaddr = adv_addr;
                out_d.len   = clen;
                out_d.last  = last_q & is_final;
                final_d     = is_final;
                cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            raddr_q <= '0;
            rlen_q  <= '0;
            out_q   <= '0;
            last_q  <= 1'b0;
            final_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
            rlen_q  <= rlen_d;
            out_q   <= out_d;
            last_q  <= last_d;
            final_q <= final_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_req.valid = (state_q == ST_SPLIT);
    assign m_req.data  = out_q;
    assign busy        = (state_q == ST_SPLIT);
    assign chunk_cnt   = cnt_q;

endmodule

// File: tb/tb_req_splitter.sv
// Self-checking bench for req_splitter with PARSE_SIZE = 4096.
module tb_req_splitter;
    import lynxTypes::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        busy;
    logic [15:0] chunk_cnt;

    metaIntf s_req_if ();
    metaIntf m_req_if ();

    req_splitter #(
        .PARSE_SIZE (4096)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_req     (s_req_if),
        .m_req     (m_req_if),
        .busy      (busy),
        .chunk_cnt (chunk_cnt)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [47:0]      vaddr;
        logic [27:0]      len;
        logic             last;
        int               n;
        logic [2:0][47:0] ea;
        logic [2:0][27:0] el;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [47:0] va, input logic [27:0] ln,
                           input logic lst, input int n,
                           input logic [47:0] a0, input logic [27:0] l0,
                           input logic [47:0] a1, input logic [27:0] l1,
                           input logic [47:0] a2, input logic [27:0] l2);
        vecs[i].vaddr = va;
        vecs[i].len   = ln;
        vecs[i].last  = lst;
        vecs[i].n     = n;
        vecs[i].ea[0] = a0;
        vecs[i].el[0] = l0;
        vecs[i].ea[1] = a1;
        vecs[i].el[1] = l1;
        vecs[i].ea[2] = a2;
        vecs[i].el[2] = l2;
    endtask

    task automatic drive_req(input logic [47:0] va, input logic [27:0] ln, input logic lst,
                             input logic [5:0] pid);
        req_t r;
        r        = '0;
        r.opcode = 5'h3;
        r.pid    = pid;
        r.dest   = pid[3:0];
        r.vaddr  = va;
        r.len    = ln;
        r.last   = lst;
        s_req_if.data  = r;
        s_req_if.valid = 1'b1;
    endtask

    // Full downstream ready: accept, then walk all chunks of vecs[i].
    task automatic run_entry(input int i);
        logic [5:0] pid;
        pid = 6'(i + 5);
        @(posedge aclk); #1;
        m_req_if.ready = 1'b1;
        drive_req(vecs[i].vaddr, vecs[i].len, vecs[i].last, pid);
        @(negedge aclk);
        check($sformatf("v%0d accept_ready", i), s_req_if.ready, 1'b1);
        @(posedge aclk); #1;
        s_req_if.valid = 1'b0;
        for (int k = 0; k < vecs[i].n; k++) begin
            @(negedge aclk);
            check($sformatf("v%0d c%0d valid", i, k), m_req_if.valid, 1'b1);
            check($sformatf("v%0d c%0d vaddr", i, k), m_req_if.data.vaddr, vecs[i].ea[k]);
            check($sformatf("v%0d c%0d len", i, k), m_req_if.data.len, vecs[i].el[k]);
            check($sformatf("v%0d c%0d last", i, k), m_req_if.data.last,
                  (k == vecs[i].n - 1) ? vecs[i].last : 1'b0);
            check($sformatf("v%0d c%0d pid", i, k), m_req_if.data.pid, pid);
            check($sformatf("v%0d c%0d dest", i, k), m_req_if.data.dest, pid[3:0]);
            check($sformatf("v%0d c%0d busy", i, k), busy, 1'b1);
            check($sformatf("v%0d c%0d cnt", i, k), chunk_cnt, k + 1);
            check($sformatf("v%0d c%0d s_ready", i, k), s_req_if.ready,
                  (k == vecs[i].n - 1) ? 1'b1 : 1'b0);
            @(posedge aclk); #1;
        end
        @(negedge aclk);
        check($sformatf("v%0d done_valid", i), m_req_if.valid, 1'b0);
        check($sformatf("v%0d done_busy", i), busy, 1'b0);
        check($sformatf("v%0d done_cnt", i), chunk_cnt, vecs[i].n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        logic hs;

        s_req_if.valid = 1'b0;
        s_req_if.data  = '0;
        m_req_if.ready = 1'b0;

`ifdef REQ_SPLIT_ALIGN_EN
        set_vec(0, 48'h1000, 28'd10000, 1'b1, 3, 48'h1000, 4096, 48'h2000, 4096, 48'h3000, 1808);
        set_vec(1, 48'h0, 28'd0, 1'b1, 1, 48'h0, 0, 48'h0, 0, 48'h0, 0);
        set_vec(2, 48'h123, 28'd4096, 1'b0, 2, 48'h123, 3805, 48'h1000, 291, 48'h0, 0);
        set_vec(3, 48'h1F00, 28'd5000, 1'b1, 3, 48'h1F00, 256, 48'h2000, 4096, 48'h3000, 648);
        set_vec(4, 48'hFFFF_FFFF_F800, 28'd8192, 1'b1, 3,
                48'hFFFF_FFFF_F800, 2048, 48'h0, 4096, 48'h1000, 2048);
        set_vec(5, 48'h0, 28'd4097, 1'b1, 2, 48'h0, 4096, 48'h1000, 1, 48'h0, 0);
`else
        set_vec(0, 48'h1000, 28'd10000, 1'b1, 3, 48'h1000, 4096, 48'h2000, 4096, 48'h3000, 1808);
        set_vec(1, 48'h0, 28'd0, 1'b1, 1, 48'h0, 0, 48'h0, 0, 48'h0, 0);
        set_vec(2, 48'h123, 28'd4096, 1'b0, 1, 48'h123, 4096, 48'h0, 0, 48'h0, 0);
        set_vec(3, 48'h1F00, 28'd5000, 1'b1, 2, 48'h1F00, 4096, 48'h2F00, 904, 48'h0, 0);
        set_vec(4, 48'hFFFF_FFFF_F800, 28'd8192, 1'b1, 2,
                48'hFFFF_FFFF_F800, 4096, 48'h800, 4096, 48'h0, 0);
        set_vec(5, 48'h0, 28'd4097, 1'b1, 2, 48'h0, 4096, 48'h1000, 1, 48'h0, 0);
`endif

        // Reset state.
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst m_valid", m_req_if.valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst chunk_cnt", chunk_cnt, 16'h0);
        check("rst s_ready", s_req_if.ready, 1'b0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst s_ready", s_req_if.ready, 1'b1);

        for (int i = 0; i < NVEC; i++) run_entry(i);

        // Back-to-back single-chunk requests: B loads in A's final-chunk cycle.
        @(posedge aclk); #1;
        m_req_if.ready = 1'b1;
        drive_req(48'h10000, 28'd4096, 1'b1, 6'd1);
        @(negedge aclk);
        check("b2b a_accept", s_req_if.ready, 1'b1);
        @(posedge aclk); #1;
        drive_req(48'h20000, 28'd4096, 1'b0, 6'd2);
        @(negedge aclk);
        check("b2b a_valid", m_req_if.valid, 1'b1);
        check("b2b a_vaddr", m_req_if.data.vaddr, 48'h10000);
        check("b2b a_last", m_req_if.data.last, 1'b1);
        check("b2b b_ready", s_req_if.ready, 1'b1);
        @(posedge aclk); #1;
        s_req_if.valid = 1'b0;
        @(negedge aclk);
        check("b2b b_valid", m_req_if.valid, 1'b1);
        check("b2b b_vaddr", m_req_if.data.vaddr, 48'h20000);
        check("b2b b_pid", m_req_if.data.pid, 6'd2);
        check("b2b b_last", m_req_if.data.last, 1'b0);
        check("b2b b_busy", busy, 1'b1);
        check("b2b b_cnt", chunk_cnt, 16'd1);
        @(posedge aclk); #1;
        @(negedge aclk);
        check("b2b idle_valid", m_req_if.valid, 1'b0);
        check("b2b idle_busy", busy, 1'b0);

        // Random backpressure on vecs[0]; every stalled cycle must show the same chunk.
        @(posedge aclk); #1;
        m_req_if.ready = 1'b0;
        drive_req(vecs[0].vaddr, vecs[0].len, vecs[0].last, 6'd9);
        @(posedge aclk); #1;
        s_req_if.valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < vecs[0].n && cyc < 200) begin
            m_req_if.ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge aclk);
            check($sformatf("bp cyc%0d valid", cyc), m_req_if.valid, 1'b1);
            check($sformatf("bp cyc%0d vaddr", cyc), m_req_if.data.vaddr, vecs[0].ea[idx]);
            check($sformatf("bp cyc%0d len", cyc), m_req_if.data.len, vecs[0].el[idx]);
            check($sformatf("bp cyc%0d cnt", cyc), chunk_cnt, idx + 1);
            hs = m_req_if.valid & m_req_if.ready;
            @(posedge aclk); #1;
            if (hs) idx++;
            cyc++;
        end
        if (idx < vecs[0].n) check("bp timeout", idx, vecs[0].n);
        m_req_if.ready = 1'b1;
        @(negedge aclk);
        check("bp done_valid", m_req_if.valid, 1'b0);
        check("bp done_cnt", chunk_cnt, 16'd3);

        // Reset after the first chunk of a 3-chunk request.
        @(posedge aclk); #1;
        drive_req(vecs[0].vaddr, vecs[0].len, vecs[0].last, 6'd4);
        @(posedge aclk); #1;
        s_req_if.valid = 1'b0;
        @(negedge aclk);
        check("mrst first_valid", m_req_if.valid, 1'b1);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        @(negedge aclk);
        check("mrst valid", m_req_if.valid, 1'b0);
        check("mrst busy", busy, 1'b0);
        check("mrst cnt", chunk_cnt, 16'h0);
        check("mrst s_ready", s_req_if.ready, 1'b0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("mrst release_valid", m_req_if.valid, 1'b0);
        check("mrst release_ready", s_req_if.ready, 1'b1);
        run_entry(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
